// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 sensor-bus emulator and capture path:
// vertical state encoding, QCIF geometry and framebuffer address width.
package ov7670_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_V_BP   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_V_FP   = 3'd4
  } vstate_t;

  localparam int QCIF_H_BYTES = 176;
  localparam int QCIF_LINES   = 144;
  localparam int FB_ADDR_W    = 16;

endpackage

// File: rtl/ov7670_timing_gen.sv
// Frame/line timing for the OV7670 emulator: horizontal counter, per-phase
// line counter and vertical FSM, with combinational internal strobes.
module ov7670_timing_gen
  import ov7670_pkg::*;
#(
  parameter int H_BYTES     = QCIF_H_BYTES,
  parameter int H_BLANK     = 144,
  parameter int V_LINES     = QCIF_LINES,
  parameter int VSYNC_LINES = 3,
  parameter int V_BP_LINES  = 17,
  parameter int V_FP_LINES  = 10
) (
  input  logic       pclk_24,
  input  logic       reset_n,
  input  logic       i_start,
  output logic       o_vsync_i,
  output logic       o_href_i,
  output logic       o_busy_i,
  output logic [7:0] o_line,
  output logic [7:0] o_col,
  output logic       o_frame_start,
  output logic       o_frame_end
);

  localparam int LP = H_BYTES + H_BLANK;

  vstate_t     r_state;
  logic [15:0] r_hc;
  logic [15:0] r_line_cnt;
  logic        w_line_end;
  logic        w_phase_end;
  vstate_t     w_next_phase;
  vstate_t     w_first_phase;

  function automatic logic [15:0] phase_len(input logic [2:0] st);
    case (st)
      ST_VSYNC:  phase_len = 16'(VSYNC_LINES);
      ST_V_BP:   phase_len = 16'(V_BP_LINES);
      ST_ACTIVE: phase_len = 16'(V_LINES);
      ST_V_FP:   phase_len = 16'(V_FP_LINES);
      default:   phase_len = 16'd0;
    endcase
  endfunction

  // First phase at or after 'from' with non-zero length; IDLE means the frame is over.
  function automatic vstate_t first_phase(input logic [2:0] from);
    vstate_t st;
    st = ST_IDLE;
    for (int i = 4; i >= 1; i--) begin
      if ((3'(i) >= from) && (phase_len(3'(i)) != 16'd0)) st = vstate_t'(3'(i));
    end
    return st;
  endfunction

  assign w_first_phase = first_phase(3'd1);
  assign w_next_phase  = first_phase(r_state + 3'd1);
  assign w_line_end    = (r_hc == 16'(LP - 1));
  assign w_phase_end   = (r_state != ST_IDLE) && w_line_end &&
                         (r_line_cnt == phase_len(r_state) - 16'd1);

  assign o_frame_end   = w_phase_end && (w_next_phase == ST_IDLE);
  assign o_frame_start = i_start && ((r_state == ST_IDLE) || o_frame_end);
  assign o_vsync_i     = (r_state == ST_VSYNC);
  assign o_href_i      = (r_state == ST_ACTIVE) && (r_hc < 16'(H_BYTES));
  assign o_busy_i      = (r_state != ST_IDLE);
  assign o_line        = r_line_cnt[7:0];
  assign o_col         = r_hc[7:0];

  // Vertical FSM with horizontal and per-phase line counters
  always_ff @(posedge pclk_24) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_hc       <= 16'd0;
      r_line_cnt <= 16'd0;
    end else if (r_state == ST_IDLE) begin
      r_hc       <= 16'd0;
      r_line_cnt <= 16'd0;
      r_state    <= i_start ? w_first_phase : ST_IDLE;
    end else if (w_phase_end) begin
      r_hc       <= 16'd0;
      r_line_cnt <= 16'd0;
      if (o_frame_end) begin
        r_state <= i_start ? w_first_phase : ST_IDLE;
      end else begin
        r_state <= w_next_phase;
      end
    end else if (w_line_end) begin
      r_hc       <= 16'd0;
      r_line_cnt <= r_line_cnt + 16'd1;
    end else begin
      r_hc <= r_hc + 16'd1;
    end
  end

endmodule

// File: rtl/ov7670_frame_source.sv
// OV7670 sensor emulator: drives vsync/href/d from a framebuffer (1-cycle RAM)
// or a diagonal test pattern, aligned to the RAM latency by a 2-stage pipeline.
module ov7670_frame_source
  import ov7670_pkg::*;
#(
  parameter int H_BYTES     = QCIF_H_BYTES,
  parameter int H_BLANK     = 144,
  parameter int V_LINES     = QCIF_LINES,
  parameter int VSYNC_LINES = 3,
  parameter int V_BP_LINES  = 17,
  parameter int V_FP_LINES  = 10
) (
  input  logic                 pclk_24,
  input  logic                 reset_n,
  input  logic                 i_start,
  input  logic                 i_pattern_en,
  input  logic [7:0]           i_fb_din,
  output logic [FB_ADDR_W-1:0] o_fb_addr,
  output logic                 o_vsync,
  output logic                 o_href,
  output logic [7:0]           o_d,
  output logic                 o_busy,
  output logic                 o_frame_done
);

  logic       w_vsync_i;
  logic       w_href_i;
  logic       w_busy_i;
  logic [7:0] w_line;
  logic [7:0] w_col;
  logic       w_frame_start;
  logic       w_frame_end;
  logic [7:0] w_pat_byte;

  logic [FB_ADDR_W-1:0] r_k;
  logic                 r_pat_mode;
  logic r_s0_vsync, r_s0_href, r_s0_busy, r_s0_end, r_s0_mode;
  logic r_s1_vsync, r_s1_href, r_s1_busy, r_s1_end, r_s1_mode;
  logic r_s2_end;
  logic [7:0] r_s0_pat, r_s1_pat;

  ov7670_timing_gen #(
    .H_BYTES    (H_BYTES),
    .H_BLANK    (H_BLANK),
    .V_LINES    (V_LINES),
    .VSYNC_LINES(VSYNC_LINES),
    .V_BP_LINES (V_BP_LINES),
    .V_FP_LINES (V_FP_LINES)
  ) u_timing (
    .pclk_24      (pclk_24),
    .reset_n      (reset_n),
    .i_start      (i_start),
    .o_vsync_i    (w_vsync_i),
    .o_href_i     (w_href_i),
    .o_busy_i     (w_busy_i),
    .o_line       (w_line),
    .o_col        (w_col),
    .o_frame_start(w_frame_start),
    .o_frame_end  (w_frame_end)
  );

  assign w_pat_byte = w_line + w_col;

  // Byte index and RAM address; source mode is frozen for the whole frame
  always_ff @(posedge pclk_24) begin
    if (!reset_n) begin
      r_k        <= '0;
      o_fb_addr  <= '0;
      r_pat_mode <= 1'b0;
    end else if (w_frame_start) begin
      r_k        <= '0;
      o_fb_addr  <= '0;
      r_pat_mode <= i_pattern_en;
    end else if (w_href_i) begin
      o_fb_addr <= r_k;
      r_k       <= r_k + 16'd1;
    end else begin
      o_fb_addr <= o_fb_addr;
      r_k       <= r_k;
    end
  end

  // Alignment pipeline: stage 0 runs beside fb_addr, stage 1 beside fb_din.
  // frame_done takes one extra stage so it follows the last V_FP output cycle.
  always_ff @(posedge pclk_24) begin
    if (!reset_n) begin
      r_s0_vsync   <= 1'b0;
      r_s0_href    <= 1'b0;
      r_s0_busy    <= 1'b0;
      r_s0_end     <= 1'b0;
      r_s0_mode    <= 1'b0;
      r_s0_pat     <= 8'd0;
      r_s1_vsync   <= 1'b0;
      r_s1_href    <= 1'b0;
      r_s1_busy    <= 1'b0;
      r_s1_end     <= 1'b0;
      r_s1_mode    <= 1'b0;
      r_s1_pat     <= 8'd0;
      r_s2_end     <= 1'b0;
      o_vsync      <= 1'b0;
      o_href       <= 1'b0;
      o_d          <= 8'd0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      r_s0_vsync   <= w_vsync_i;
      r_s0_href    <= w_href_i;
      r_s0_busy    <= w_busy_i;
      r_s0_end     <= w_frame_end;
      r_s0_mode    <= r_pat_mode;
      r_s0_pat     <= w_pat_byte;
      r_s1_vsync   <= r_s0_vsync;
      r_s1_href    <= r_s0_href;
      r_s1_busy    <= r_s0_busy;
      r_s1_end     <= r_s0_end;
      r_s1_mode    <= r_s0_mode;
      r_s1_pat     <= r_s0_pat;
      r_s2_end     <= r_s1_end;
      o_vsync      <= r_s1_vsync;
      o_href       <= r_s1_href;
      o_d          <= r_s1_href ? (r_s1_mode ? r_s1_pat : i_fb_din) : 8'd0;
      o_busy       <= r_s1_busy | r_s2_end;
      o_frame_done <= r_s2_end;
    end
  end

endmodule

// File: doc/ov7670_frame_source.md
# ov7670_frame_source

Synthesisable OV7670 sensor emulator: it reads a byte-wide framebuffer, or generates a test pattern, and drives `vsync`, `href` and `d[7:0]` with OV7670-style frame and line timing. It is the transmitting end of the sensor pixel bus and sits in `pclk_24`. Its outputs connect directly to the capture block's sensor inputs, giving closed-loop capture testing on the board and in simulation without a physical camera.

## Interface
- `H_BYTES`, default 176: bytes per active line (one byte per `href` cycle).
- `H_BLANK`, default 144: `href`-low cycles per line after the active bytes. Must be ≥1.
- `V_LINES`, default 144: active lines per frame.
- `VSYNC_LINES`, default 3: lines per frame with `vsync` high.
- `V_BP_LINES`, default 17: blank lines between `vsync` falling and the first active line.
- `V_FP_LINES`, default 10: blank lines after the last active line.
- `pclk_24` input 1: 24 MHz pixel clock; all logic on its rising edge.
- `reset_n` input 1: reset, synchronous, active-low.
- `start` input 1: run request. Level-sensitive; frames repeat while high.
- `pattern_en` input 1: 1 selects the test pattern, 0 selects the framebuffer. Sampled at frame start.
- `fb_din` input 8: framebuffer read data. The RAM has 1-cycle read latency.
- `fb_addr` output 16: framebuffer read address.
- `vsync` output 1: vertical sync, active high.
- `href` output 1: horizontal reference; high during active bytes.
- `d` output 8: pixel byte; valid when `href`=1, otherwise 0.
- `busy` output 1: a frame is in progress.
- `frame_done` output 1: single-cycle pulse at the end of each frame.

## Operation
- Line period is `LP = H_BYTES + H_BLANK` cycles in every vertical phase. A horizontal counter `hc` runs 0..LP-1. Active bytes are at `hc` < `H_BYTES`.
- Vertical FSM (`line_cnt` counts lines within each state):
  - IDLE: if `start`=1, go to VSYNC, set `hc`=0 and `line_cnt`=0, latch `pattern_en`, and clear the byte index `k` to 0.
  - VSYNC: lasts `VSYNC_LINES` lines, then V_BP. Lasts `V_BP_LINES` lines, then ACTIVE. Lasts `V_LINES` lines, then V_FP. Lasts `V_FP_LINES` lines.
  - End of V_FP: if `start`=1, go to VSYNC with no gap cycle; otherwise go to IDLE.
  - A zero-length phase (a parameter set to 0) is skipped.
- Deasserting `start` mid-frame does not abort; the current frame completes.
- Internal signals:
  - vsync_i = (state==VSYNC).
  - href_i = (state==ACTIVE && `hc` < `H_BYTES`).
  - `k` increments on each href_i cycle and ranges 0..H_BYTES·V_LINES−1.
- Data source per byte `k` (line `l`, column `c`):
  - Framebuffer mode: `d` = mem[k].
  - Pattern mode: `d` = (l + c) mod 256, with `l` and `c` truncated to 8 bits.
- Width rule: H_BYTES·V_LINES ≤ 65536. `fb_addr` is 16 bits, never wraps within a frame, and resets to 0 at every frame start.
- `busy` is high from the first output cycle of VSYNC through the cycle in which `frame_done` is high, and stays high across back-to-back frames.
- `frame_done` pulses in the output cycle that follows the last V_FP cycle, after pipeline alignment.
- Reset (at any time, including mid-frame), on the next edge:
  - state = IDLE; all counters = 0.
  - `fb_addr`=0, `vsync`=0, `href`=0, `d`=0, `busy`=0, `frame_done`=0.
  - Pipeline contents are discarded.

## Timing
- Output pipeline depth is 2 cycles. `vsync`, `href`, `d`, `busy` and `frame_done` are delayed by 2 registers from the internal timing so that they align with the RAM data.
- `fb_addr` is registered and equals `k` one cycle after the internal cycle that will consume it. The RAM returns mem[k] on `fb_din` the following cycle, and `d` registers it. So `fb_addr`=k leads `d`=mem[k] by exactly 2 cycles.
- `fb_addr` holds its last value outside active bytes.
- If edge E0 samples `start`=1 in IDLE:
  - `vsync` is first high after edge E0+3 (internal VSYNC from E0+1, plus 2 pipeline stages).
  - `busy` rises with `vsync`.
- `vsync` is high for exactly `VSYNC_LINES`·LP cycles.
- Each `href` pulse is exactly `H_BYTES` cycles and is followed by `H_BLANK` low cycles.
- Frame length is (`VSYNC_LINES`+`V_BP_LINES`+`V_LINES`+`V_FP_LINES`)·LP cycles.
- `vsync` and `href` are never high in the same cycle.
- `d`=0 whenever `href`=0.

## Structure
- Shared package `ov7670_pkg` holds:
  - the vertical state enum (IDLE, VSYNC, V_BP, ACTIVE, V_FP);
  - QCIF constants (176, 144) shared with the capture path;
  - the framebuffer address width (16).
- One sub-module, `ov7670_timing_gen`: the `hc`/`line_cnt` counters and the vertical FSM, producing vsync_i, href_i, line/column indices, the frame-start strobe and the frame-end strobe.
- The top level adds address generation, the pattern/RAM mux and the 2-stage alignment pipeline.

## Test plan
All scenarios use small parameters: `H_BYTES`=4, `H_BLANK`=2, `V_LINES`=3, `VSYNC_LINES`=1, `V_BP_LINES`=1, `V_FP_LINES`=1. This gives LP=6 and a 36-cycle frame.

- Framebuffer mode, single frame:
  - Stimulus: RAM model mem[i]=i+0x10, `start` pulsed for 1 cycle.
  - Required: `vsync` high for 6 cycles; three `href` pulses of 4 cycles with 2-cycle gaps; `d` = 0x10..0x1B in order; `fb_addr` 0..11 each leading `d` by 2 cycles; one `frame_done` pulse; then `busy`=0 and all outputs 0.
- Pattern mode:
  - Stimulus: `pattern_en`=1.
  - Required: line 0 `d` = 00,01,02,03; line 1 `d` = 01,02,03,04; line 2 `d` = 02,03,04,05.
  - With `H_BYTES`=300: line 0 byte 256 = 0x00.
- Continuous run:
  - Stimulus: `start` held high for 3 frames.
  - Required: frames exactly 36 cycles apart; `fb_addr` returns to 0 each frame; `busy` continuously high; three `frame_done` pulses.
- `start` dropped mid-frame:
  - Stimulus: `start` deasserted during ACTIVE line 1.
  - Required: the frame completes all 12 bytes, `frame_done` pulses, and no further `vsync` follows.
- Reset mid-frame:
  - Stimulus: `reset_n`=0 for 1 cycle during `href`.
  - Required: after that edge, all outputs are 0. A subsequent `start` produces a frame starting at `fb_addr`=0 with correct timing.
- `pattern_en` toggled mid-frame:
  - Required: no effect until the next frame start.
